// File: rtl/wb_arb_pkg.sv
// Shared types and helpers for the Wishbone two-master arbiter and its
// outstanding-transfer counter.
package wb_arb_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      GRANT0 = 2'd1,
      GRANT1 = 2'd2
   } state_t;

   function automatic int cnt_width(input int max_out);
      return $clog2(max_out + 1);
   endfunction

endpackage

// File: rtl/wb_outstanding_cnt.sv
// Counts transfers accepted by the slave but not yet acked; flags the
// pipelining limit and qualifies incoming acks against a non-empty count.
module wb_outstanding_cnt
   import wb_arb_pkg::*;
#(
   parameter int max_outstanding = 4,
   localparam int cnt_w = cnt_width(max_outstanding)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             accept,
   input  logic             ack,
   output logic [cnt_w-1:0] cnt,
   output logic             full,
   output logic             ack_valid
);

   logic inc;

   assign full      = (cnt == cnt_w'(max_outstanding));
   assign ack_valid = ack & (cnt != '0);
   assign inc       = accept & ~full;

   // An ack with nothing outstanding is stray and never underflows the count.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (inc && !ack_valid) begin
         cnt <= cnt + cnt_w'(1);
      end else if (!inc && ack_valid) begin
         cnt <= cnt - cnt_w'(1);
      end
   end

endmodule

// File: rtl/wb_arbiter2.sv
// Round-robin arbiter letting two pipelined Wishbone masters share one slave;
// the grant is held for the whole bus cycle.
module wb_arbiter2
   import wb_arb_pkg::*;
#(
   parameter int adr_width       = 16,
   parameter int dat_width       = 16,
   parameter int max_outstanding = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 m0_cyc,
   input  logic                 m0_stb,
   input  logic                 m0_we,
   input  logic [adr_width-1:0] m0_adr,
   input  logic [dat_width-1:0] m0_wdat,
   output logic [dat_width-1:0] m0_rdat,
   output logic                 m0_ack,
   output logic                 m0_stall,
   input  logic                 m1_cyc,
   input  logic                 m1_stb,
   input  logic                 m1_we,
   input  logic [adr_width-1:0] m1_adr,
   input  logic [dat_width-1:0] m1_wdat,
   output logic [dat_width-1:0] m1_rdat,
   output logic                 m1_ack,
   output logic                 m1_stall,
   output logic                 s_cyc,
   output logic                 s_stb,
   output logic                 s_we,
   output logic [adr_width-1:0] s_adr,
   output logic [dat_width-1:0] s_wdat,
   input  logic [dat_width-1:0] s_rdat,
   input  logic                 s_ack,
   input  logic                 s_stall
);

   localparam int cnt_w = cnt_width(max_outstanding);

   state_t           state;
   logic             last;
   logic [cnt_w-1:0] cnt;
   logic             full;
   logic             ack_valid;
   logic             accept;
   logic             release_grant;
   logic             clr;

   // last remembers the most recent grant, so a tie goes to the other master.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= IDLE;
         last  <= 1'b1;
      end else begin
         case (state)
            IDLE: begin
               if (m0_cyc && (!m1_cyc || last)) begin
                  state <= GRANT0;
                  last  <= 1'b0;
               end else if (m1_cyc) begin
                  state <= GRANT1;
                  last  <= 1'b1;
               end
            end
            GRANT0:  if (!m0_cyc) state <= IDLE;
            GRANT1:  if (!m1_cyc) state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   always_comb begin
      s_cyc    = 1'b0;
      s_stb    = 1'b0;
      s_we     = m0_we;
      s_adr    = m0_adr;
      s_wdat   = m0_wdat;
      m0_ack   = 1'b0;
      m1_ack   = 1'b0;
      m0_stall = 1'b1;
      m1_stall = 1'b1;
      case (state)
         GRANT0: begin
            s_cyc    = m0_cyc;
            s_stb    = m0_stb & ~full;
            m0_stall = s_stall | full;
            m0_ack   = ack_valid;
         end
         GRANT1: begin
            s_cyc    = m1_cyc;
            s_stb    = m1_stb & ~full;
            s_we     = m1_we;
            s_adr    = m1_adr;
            s_wdat   = m1_wdat;
            m1_stall = s_stall | full;
            m1_ack   = ack_valid;
         end
         default: ;
      endcase
   end

   assign m0_rdat = s_rdat;
   assign m1_rdat = s_rdat;

   // Dropping cyc with transfers in flight is an abort: their late acks must
   // not be credited to the next grant.
   assign accept        = s_cyc & s_stb & ~s_stall;
   assign release_grant = ((state == GRANT0) & ~m0_cyc) | ((state == GRANT1) & ~m1_cyc);
   assign clr           = release_grant & (cnt != '0);

   wb_outstanding_cnt #(
      .max_outstanding(max_outstanding)
   ) u_cnt (
      .clk      (clk),
      .rst      (rst),
      .clr      (clr),
      .accept   (accept),
      .ack      (s_ack),
      .cnt      (cnt),
      .full     (full),
      .ack_valid(ack_valid)
   );

endmodule

// File: tb/tb_wb_arbiter2.sv
// Scoreboard bench for wb_arbiter2: random masters and a delayed-ack slave,
// checked against a grant/outstanding reference model.
module tb_wb_arbiter2;

   localparam int AW   = 16;
   localparam int DW   = 16;
   localparam int MAXO = 4;

   logic          clk = 1'b0;
   logic          rst;
   logic          m_cyc[2], m_stb[2], m_we[2], m_ack[2], m_stall[2];
   logic [AW-1:0] m_adr[2];
   logic [DW-1:0] m_wdat[2], m_rdat[2];
   logic          s_cyc, s_stb, s_we, s_ack, s_stall;
   logic [AW-1:0] s_adr;
   logic [DW-1:0] s_wdat, s_rdat;

   int tests = 0, fails = 0;
   int own = -1, last = 1, cnt = 0;
   logic [DW-1:0] exp_q0[$], exp_q1[$];
   int ack_seen[2];
   int first_ack = -1, full_seen = 0;
   int dly = 1, ncyc = 0;
   bit stall_en = 0, flush_ab = 1, stray = 0, gaps = 0;
   int pend_due[$];
   logic [DW-1:0] pend_dat[$];

   always #5 clk = ~clk;

   wb_arbiter2 #(.adr_width(AW), .dat_width(DW), .max_outstanding(MAXO)) dut (
      .clk(clk), .rst(rst),
      .m0_cyc(m_cyc[0]), .m0_stb(m_stb[0]), .m0_we(m_we[0]), .m0_adr(m_adr[0]),
      .m0_wdat(m_wdat[0]), .m0_rdat(m_rdat[0]), .m0_ack(m_ack[0]), .m0_stall(m_stall[0]),
      .m1_cyc(m_cyc[1]), .m1_stb(m_stb[1]), .m1_we(m_we[1]), .m1_adr(m_adr[1]),
      .m1_wdat(m_wdat[1]), .m1_rdat(m_rdat[1]), .m1_ack(m_ack[1]), .m1_stall(m_stall[1]),
      .s_cyc(s_cyc), .s_stb(s_stb), .s_we(s_we), .s_adr(s_adr), .s_wdat(s_wdat),
      .s_rdat(s_rdat), .s_ack(s_ack), .s_stall(s_stall)
   );

   function automatic logic [DW-1:0] rd_val(input logic [AW-1:0] a);
      if (a == AW'(16'h0010)) return DW'(16'hBEEF);
      return DW'(a ^ AW'(16'h5A3C));
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: who owns the bus, who won last, how many are in flight.
   initial begin
      int acc, dec;
      forever begin
         @(posedge clk or negedge rst);
         if (!rst) begin
            own = -1; last = 1; cnt = 0;
            exp_q0.delete(); exp_q1.delete();
         end else if (own < 0) begin
            if (m_cyc[0] && m_cyc[1]) own = (last == 0) ? 1 : 0;
            else if (m_cyc[0]) own = 0;
            else if (m_cyc[1]) own = 1;
            if (own >= 0) last = own;
         end else begin
            acc = (m_cyc[own] && m_stb[own] && cnt < MAXO && !s_stall) ? 1 : 0;
            dec = (s_ack && cnt > 0) ? 1 : 0;
            if (acc == 1) begin
               if (own == 0) exp_q0.push_back(rd_val(m_adr[0]));
               else exp_q1.push_back(rd_val(m_adr[1]));
            end
            cnt = cnt + acc - dec;
            if (!m_cyc[own]) begin
               if (own == 0) exp_q0.delete(); else exp_q1.delete();
               own = -1; cnt = 0;
            end
         end
      end
   end

   // Slave: in-order acks after dly cycles; drops pending work when cyc falls.
   initial begin
      bit acc, cyc;
      logic [AW-1:0] a;
      int due;
      forever begin
         @(negedge clk);
         acc = s_cyc && s_stb && !s_stall; cyc = s_cyc; a = s_adr;
         @(posedge clk);
         ncyc++;
         if (!rst) begin
            pend_due.delete(); pend_dat.delete();
         end else begin
            if (acc) begin
               due = ncyc + dly - 1;
               if (pend_due.size() > 0 && due <= pend_due[$]) due = pend_due[$] + 1;
               pend_due.push_back(due); pend_dat.push_back(rd_val(a));
            end
            if (!cyc && flush_ab) begin
               pend_due.delete(); pend_dat.delete();
            end
         end
         #1;
         s_ack = 1'b0;
         s_rdat = DW'($urandom);
         if (rst && pend_due.size() > 0 && pend_due[0] <= ncyc) begin
            s_ack = 1'b1;
            s_rdat = pend_dat.pop_front();
            void'(pend_due.pop_front());
         end
         if (stray) s_ack = 1'b1;
         s_stall = stall_en && ($urandom_range(0, 3) == 0);
      end
   end

   // Monitor: per-cycle control against the model, read data against the queues.
   initial begin
      bit e_cyc, e_stb, e_st0, e_st1, e_ak0, e_ak1, full;
      forever begin
         @(negedge clk);
         full = (cnt == MAXO);
         e_cyc = 0; e_stb = 0; e_st0 = 1; e_st1 = 1; e_ak0 = 0; e_ak1 = 0;
         if (own == 0) begin
            e_cyc = m_cyc[0]; e_stb = m_stb[0] && !full;
            e_st0 = s_stall || full; e_ak0 = s_ack && cnt > 0;
         end else if (own == 1) begin
            e_cyc = m_cyc[1]; e_stb = m_stb[1] && !full;
            e_st1 = s_stall || full; e_ak1 = s_ack && cnt > 0;
         end
         check("ctrl{cyc,stb,st1,st0,ak1,ak0}",
               64'({s_cyc, s_stb, m_stall[1], m_stall[0], m_ack[1], m_ack[0]}),
               64'({e_cyc, e_stb, e_st1, e_st0, e_ak1, e_ak0}));
         if (own >= 0)
            check("pass{we,adr,wdat}", 64'({s_we, s_adr, s_wdat}),
                  64'({m_we[own], m_adr[own], m_wdat[own]}));
         check("rdat_bcast", 64'({m_rdat[0], m_rdat[1]}), 64'({s_rdat, s_rdat}));
         if (own == 0 && full && m_stall[0]) full_seen++;
         for (int m = 0; m < 2; m++) begin
            if (m_ack[m]) begin
               ack_seen[m]++;
               if (first_ack < 0) first_ack = m;
               if ((m == 0 ? exp_q0.size() : exp_q1.size()) == 0) begin
                  tests++; fails++;
                  $display("FAIL spurious_ack m%0d: got ack, expected none at %0t", m, $time);
               end else begin
                  check($sformatf("rdat_m%0d", m), 64'(m_rdat[m]),
                        64'(m == 0 ? exp_q0.pop_front() : exp_q1.pop_front()));
               end
            end
         end
      end
   end

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic new_req(input int m, input int fix);
      if (fix >= 0) begin
         m_adr[m] = AW'(fix); m_we[m] = 1'b0;
      end else begin
         m_adr[m] = AW'($urandom); m_we[m] = 1'($urandom_range(0, 1));
      end
      m_wdat[m] = DW'($urandom);
   endtask

   task automatic run_burst(input int m, input int n, input bit abort, input int fix);
      int issued = 0, acked = 0, budget = 0;
      bit acc, ack;
      m_cyc[m] = 1'b1; m_stb[m] = 1'b1; new_req(m, fix);
      forever begin
         @(negedge clk);
         acc = m_stb[m] && !m_stall[m]; ack = m_ack[m];
         @(posedge clk); #1;
         if (acc) issued++;
         if (ack) acked++;
         if (acc || !m_stb[m]) begin
            m_stb[m] = (issued < n) && (!gaps || $urandom_range(0, 2) != 0);
            if (m_stb[m]) new_req(m, fix);
         end
         if (issued >= n && (abort || acked >= n)) break;
         budget++;
         if (budget > 400) begin
            tests++; fails++;
            $display("FAIL burst_timeout m%0d: issued %0d acked %0d, required %0d", m, issued, acked, n);
            break;
         end
      end
      m_cyc[m] = 1'b0; m_stb[m] = 1'b0;
   endtask

   task automatic clr_counts();
      ack_seen[0] = 0; ack_seen[1] = 0; first_ack = -1; full_seen = 0;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      rst = 1'b0; s_ack = 1'b0; s_stall = 1'b0; s_rdat = '0;
      for (int m = 0; m < 2; m++) begin
         m_cyc[m] = 1'b0; m_stb[m] = 1'b0; m_we[m] = 1'b0; m_adr[m] = '0; m_wdat[m] = '0;
      end
      clr_counts();
      repeat (3) @(posedge clk);
      #1;
      check("reset_idle", 64'({s_cyc, s_stb, m_stall[0], m_stall[1], m_ack[0], m_ack[1]}), 64'(6'b001100));
      rst = 1'b1;
      idle(1);
      check("post_reset_idle", 64'({s_cyc, m_stall[0], m_stall[1]}), 64'(3'b011));

      // single master read
      dly = 1; clr_counts();
      run_burst(1, 1, 0, 16'h0010);
      idle(3);
      check("single_m1_acks", 64'(ack_seen[1]), 64'(1));
      check("single_m0_acks", 64'(ack_seen[0]), 64'(0));

      // tie, then tie again
      clr_counts();
      fork
         run_burst(0, 2, 0, -1);
         run_burst(1, 2, 0, -1);
      join
      check("tie1_first", 64'(first_ack), 64'(0));
      idle(2); clr_counts();
      fork
         run_burst(0, 2, 0, -1);
         run_burst(1, 2, 0, -1);
      join
      check("tie2_first", 64'(first_ack), 64'(0));
      check("tie2_m1_acks", 64'(ack_seen[1]), 64'(2));

      // pipelining limit
      idle(2); dly = 8; clr_counts();
      run_burst(0, 6, 0, -1);
      check("pipe_m0_acks", 64'(ack_seen[0]), 64'(6));
      check("pipe_m1_acks", 64'(ack_seen[1]), 64'(0));
      check("pipe_full_stall", 64'(full_seen > 0), 64'(1));

      // steady accept+ack overlap
      idle(2); dly = 2; clr_counts();
      run_burst(0, 8, 0, -1);
      check("overlap_m0_acks", 64'(ack_seen[0]), 64'(8));

      // stray acks in IDLE and in an empty grant
      idle(2); clr_counts();
      @(negedge clk); stray = 1; @(negedge clk); stray = 0;
      idle(1); m_cyc[1] = 1'b1; idle(3);
      @(negedge clk); stray = 1; @(negedge clk); stray = 0;
      idle(1); m_cyc[1] = 1'b0; idle(2);
      check("stray_m0_acks", 64'(ack_seen[0]), 64'(0));
      check("stray_m1_acks", 64'(ack_seen[1]), 64'(0));
      dly = 8; clr_counts();
      run_burst(1, 5, 0, -1);
      check("after_stray_m1_acks", 64'(ack_seen[1]), 64'(5));

      // abort with three in flight; late acks must vanish
      idle(2); flush_ab = 0; dly = 8; clr_counts();
      run_burst(1, 3, 1, -1);
      idle(16);
      check("abort_m1_acks", 64'(ack_seen[1]), 64'(0));
      check("abort_m0_acks", 64'(ack_seen[0]), 64'(0));
      flush_ab = 1;

      // reset mid-burst
      dly = 20; m_cyc[0] = 1'b1; m_stb[0] = 1'b1; new_req(0, -1);
      idle(4);
      @(negedge clk); #2; rst = 1'b0; #1;
      check("reset_mid_burst", 64'({s_cyc, s_stb, m_stall[0]}), 64'(3'b001));
      m_cyc[0] = 1'b0; m_stb[0] = 1'b0;
      @(posedge clk); #1; rst = 1'b1;
      idle(2);

      // randomized traffic
      gaps = 1;
      for (int it = 0; it < 40; it++) begin
         dly = int'($urandom_range(1, 9)); stall_en = 1'($urandom_range(0, 1));
         fork
            begin
               idle(int'($urandom_range(1, 3)));
               if ($urandom_range(0, 3) != 0)
                  run_burst(0, int'($urandom_range(1, 7)), $urandom_range(0, 4) == 0, -1);
            end
            begin
               idle(int'($urandom_range(1, 3)));
               if ($urandom_range(0, 3) != 0)
                  run_burst(1, int'($urandom_range(1, 7)), $urandom_range(0, 4) == 0, -1);
            end
         join
         idle(2);
      end
      stall_en = 0;
      idle(4);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
